// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: control from decode/execute, ROM address/data and the
// IF/ID pipeline register outputs. The master side is the fetch unit.
interface inst_fetch_if #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned INST_W = 16
);
  logic              enable;
  logic              stall;
  logic              jump;
  logic [PC_W-1:0]   jump_target;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;
  logic [PC_W-1:0]   iAddress;
  logic [INST_W-1:0] oInstruction;
  logic [INST_W-1:0] if_id_inst;
  logic [PC_W-1:0]   if_id_pc;
  logic              if_id_valid;
  logic [2:0]        fetch_state;
  logic              bound_fault;

  modport master (
    input  enable, stall, jump, jump_target, branch_taken, branch_target,
           oInstruction,
    output iAddress, if_id_inst, if_id_pc, if_id_valid, fetch_state,
           bound_fault
  );

  modport slave (
    output enable, stall, jump, jump_target, branch_taken, branch_target,
           oInstruction,
    input  iAddress, if_id_inst, if_id_pc, if_id_valid, fetch_state,
           bound_fault
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the ROM and fills IF/ID.
// Define IFETCH_BOUND_TRAP_EN to trap (HALT + bound_fault) instead of wrapping past ROM_LAST.
module inst_fetch_unit #(
  parameter int unsigned       PC_W     = 10,
  parameter int unsigned       INST_W   = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [PC_W-1:0]   ROM_LAST = '1,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  inst_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_STALLED = 3'd2,
    S_FLUSH   = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] if_id_inst_q, if_id_inst_d;
  logic [PC_W-1:0]   if_id_pc_q, if_id_pc_d;
  logic              if_id_valid_q, if_id_valid_d;

  logic              active, redirect, fetch, trap;
  logic [PC_W-1:0]   redirect_pc, pc_inc;

  // FLUSH behaves like RUN on its edge: the bubble is already in IF/ID and
  // the redirect target is fetched now.
  assign active      = (state_q == S_RUN) || (state_q == S_STALLED) ||
                       (state_q == S_FLUSH);
  assign redirect    = active && (bus.branch_taken || bus.jump);
  assign redirect_pc = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign fetch       = active && !redirect && !bus.stall && bus.enable;

`ifdef IFETCH_BOUND_TRAP_EN
  logic bound_fault_q, bound_fault_d;

  // ROM_LAST was fetched on the previous edge with the increment suppressed,
  // so PC and the IF/ID slot both sit on ROM_LAST.
  assign trap   = fetch && (pc_q == ROM_LAST) && if_id_valid_q &&
                  (if_id_pc_q == ROM_LAST);
  assign pc_inc = (pc_q == ROM_LAST) ? pc_q : pc_q + PC_W'(1);
  assign bus.bound_fault = bound_fault_q;
`else
  assign trap   = 1'b0;
  assign pc_inc = (pc_q == ROM_LAST) ? '0 : pc_q + PC_W'(1);
  assign bus.bound_fault = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      if_id_inst_q  <= NOP_INST;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
`ifdef IFETCH_BOUND_TRAP_EN
      bound_fault_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
`ifdef IFETCH_BOUND_TRAP_EN
      bound_fault_q <= bound_fault_d;
`endif
    end
  end

  // Next state: redirect > stall > enable=0 > trap > fetch.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.enable) state_d = S_RUN;
      S_RUN, S_STALLED, S_FLUSH: begin
        if (redirect)         state_d = S_FLUSH;
        else if (bus.stall)   state_d = S_STALLED;
        else if (!bus.enable) state_d = S_IDLE;
        else if (trap)        state_d = S_HALT;
        else                  state_d = S_RUN;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // PC and IF/ID updates; everything holds unless a redirect, trap or fetch.
  always_comb begin
    pc_d          = pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
`ifdef IFETCH_BOUND_TRAP_EN
    bound_fault_d = bound_fault_q;
`endif
    if (redirect) begin
      pc_d          = redirect_pc;
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end else if (trap) begin
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
`ifdef IFETCH_BOUND_TRAP_EN
      bound_fault_d = 1'b1;
`endif
    end else if (fetch) begin
      pc_d          = pc_inc;
      if_id_inst_d  = bus.oInstruction;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
    end
  end

  assign bus.iAddress    = pc_q;
  assign bus.if_id_inst  = if_id_inst_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.fetch_state = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed, table-driven bench for inst_fetch_unit with ROM_LAST=15 and a
// synthetic ROM whose word encodes its address.
module tb_inst_fetch_unit;

  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, STALLED = 3'd2,
                         FLUSH = 3'd3, HALT = 3'd4;
  localparam logic [15:0] NOP = 16'h0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  inst_fetch_if #(.PC_W(10), .INST_W(16)) bus ();

  inst_fetch_unit #(.PC_W(10), .INST_W(16), .RESET_PC(10'd0),
                    .ROM_LAST(10'd15), .NOP_INST(16'h0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [9:0] a);
    return {6'b101011, a};
  endfunction

  always_comb bus.oInstruction = rom(bus.iAddress);

  typedef struct {
    logic        en, st, jp;
    logic [9:0]  jt;
    logic        br;
    logic [9:0]  bt;
    logic [9:0]  pc, ifpc;
    logic        v;
    logic [15:0] inst;
    logic [2:0]  state;
    logic        bf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, st, jp, input logic [9:0] jt,
                              input logic br, input logic [9:0] bt,
                              input logic [9:0] pc, ifpc, input logic v,
                              input logic [15:0] inst, input logic [2:0] state,
                              input logic bf);
    vec_t r;
    r.en = en; r.st = st; r.jp = jp; r.jt = jt; r.br = br; r.bt = bt;
    r.pc = pc; r.ifpc = ifpc; r.v = v; r.inst = inst; r.state = state; r.bf = bf;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, st, jp, input logic [9:0] jt,
                       input logic br, input logic [9:0] bt);
    bus.enable = en; bus.stall = st; bus.jump = jp; bus.jump_target = jt;
    bus.branch_taken = br; bus.branch_target = bt;
  endtask

  task automatic check_all(input string tag, input logic [9:0] pc, ifpc,
                           input logic v, input logic [15:0] inst,
                           input logic [2:0] state, input logic bf);
    check({tag, ".pc"},    32'(bus.iAddress),    32'(pc));
    check({tag, ".ifpc"},  32'(bus.if_id_pc),    32'(ifpc));
    check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(v));
    check({tag, ".inst"},  32'(bus.if_id_inst),  32'(inst));
    check({tag, ".state"}, 32'(bus.fetch_state), 32'(state));
    check({tag, ".bf"},    32'(bus.bound_fault), 32'(bf));
  endtask

  initial begin
    // Expected values after the clock edge on which the inputs are applied.
    vecs.push_back(mk(1,0,0,0,0,0,   0,  0,0,NOP,     RUN,    0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,  0,1,rom(0),  RUN,    0));
    vecs.push_back(mk(1,0,0,0,0,0,   2,  1,1,rom(1),  RUN,    0));
    vecs.push_back(mk(1,0,0,0,0,0,   3,  2,1,rom(2),  RUN,    0));
    vecs.push_back(mk(1,0,0,0,0,0,   4,  3,1,rom(3),  RUN,    0));
    vecs.push_back(mk(1,0,0,0,0,0,   5,  4,1,rom(4),  RUN,    0));
    vecs.push_back(mk(1,1,0,0,0,0,   5,  4,1,rom(4),  STALLED,0));
    vecs.push_back(mk(1,1,0,0,0,0,   5,  4,1,rom(4),  STALLED,0));
    vecs.push_back(mk(1,1,0,0,0,0,   5,  4,1,rom(4),  STALLED,0));
    vecs.push_back(mk(1,0,0,0,0,0,   6,  5,1,rom(5),  RUN,    0));
    vecs.push_back(mk(1,0,0,0,0,0,   7,  6,1,rom(6),  RUN,    0));
    vecs.push_back(mk(1,0,1,100,0,0, 100,6,0,NOP,     FLUSH,  0));
    vecs.push_back(mk(1,0,0,0,0,0,   101,100,1,rom(100),RUN,  0));
    vecs.push_back(mk(1,0,0,0,0,0,   102,101,1,rom(101),RUN,  0));
    vecs.push_back(mk(1,1,1,50,1,200,200,101,0,NOP,   FLUSH,  0));
    vecs.push_back(mk(1,0,0,0,0,0,   201,200,1,rom(200),RUN,  0));
    vecs.push_back(mk(1,1,0,0,0,0,   201,200,1,rom(200),STALLED,0));
    vecs.push_back(mk(1,1,0,0,1,12,  12, 200,0,NOP,   FLUSH,  0));
    vecs.push_back(mk(1,1,0,0,0,0,   12, 200,0,NOP,   STALLED,0));
    vecs.push_back(mk(0,0,0,0,0,0,   12, 200,0,NOP,   IDLE,   0));
    vecs.push_back(mk(0,0,1,3,0,0,   12, 200,0,NOP,   IDLE,   0));
    vecs.push_back(mk(1,0,0,0,0,0,   12, 200,0,NOP,   RUN,    0));
    vecs.push_back(mk(1,0,0,0,0,0,   13, 12, 1,rom(12),RUN,   0));
    vecs.push_back(mk(1,0,0,0,0,0,   14, 13, 1,rom(13),RUN,   0));
    vecs.push_back(mk(1,0,0,0,0,0,   15, 14, 1,rom(14),RUN,   0));
`ifdef IFETCH_BOUND_TRAP_EN
    vecs.push_back(mk(1,0,0,0,0,0,   15, 15, 1,rom(15),RUN,   0));
    vecs.push_back(mk(1,0,0,0,0,0,   15, 15, 0,NOP,    HALT,  1));
    vecs.push_back(mk(1,0,1,3,0,0,   15, 15, 0,NOP,    HALT,  1));
`else
    vecs.push_back(mk(1,0,0,0,0,0,   0,  15, 1,rom(15),RUN,   0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,  0,  1,rom(0), RUN,   0));
    vecs.push_back(mk(1,0,1,3,0,0,   3,  0,  0,NOP,    FLUSH, 0));
`endif

    drive(0,0,0,0,0,0);
    #1;
    check_all("reset", 0, 0, 0, NOP, IDLE, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].st, vecs[i].jp, vecs[i].jt, vecs[i].br, vecs[i].bt);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ifpc, vecs[i].v,
                vecs[i].inst, vecs[i].state, vecs[i].bf);
    end

    // Asynchronous reset landing in the middle of a FLUSH cycle.
    @(negedge clk);
    drive(0,0,0,0,0,0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1,0,0,0,0,0);
    @(posedge clk);
    #1;
    check_all("rst6.run", 0, 0, 0, NOP, RUN, 0);
    @(negedge clk);
    drive(1,0,1,9,0,0);
    @(posedge clk);
    #1;
    check_all("rst6.flush", 9, 0, 0, NOP, FLUSH, 0);
    #2;
    reset_n = 1'b0;
    drive(1,0,1,9,0,0);
    #1;
    check_all("rst6.async", 0, 0, 0, NOP, IDLE, 0);
    @(posedge clk);
    #1;
    check_all("rst6.held", 0, 0, 0, NOP, IDLE, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0,0,0,0,0,0);
    @(posedge clk);
    #1;
    check_all("rst6.release", 0, 0, 0, NOP, IDLE, 0);
    @(negedge clk);
    drive(1,0,0,0,0,0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("rst6.refetch", 1, 0, 1, rom(0), RUN, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
